mux_rr_n: RTL and testbench

- Parametrised W-bit, N-input multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Two selection modes:
  - Fixed: an external select picks the input channel.
  - Round-robin: the block arbitrates fairly among all valid channels.
- Sits between several producers (register-file read ports, ALU, immediate path) and one consumer in the 15-bit CPU datapath.
- Replaces ad-hoc combinational selectors where back-pressure and fairness matter.

---
 rtl/mux_rr_n.sv | 144 ++++++++++++++
 tb/tb_mux_rr_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// N-input valid/ready multiplexer with a registered output stage.
// Channels are picked either by an external select or by a round-robin pointer.
module mux_rr_n #(
  parameter int WIDTH    = 15,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  input  logic                      out_ready
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  logic                load_s;
  logic                xfer_s;
  logic                fx_hit_s;
  logic                lo_hit_s;
  logic [SELW-1:0]     lo_g_s;
  logic                hi_hit_s;
  logic [SELW-1:0]     hi_g_s;
  logic                rr_hit_s;
  logic [SELW-1:0]     rr_g_s;
  logic                grant_hit_s;
  logic [SELW-1:0]     grant_g_s;
  logic [WIDTH-1:0]    gnt_data_s;
  logic [CHANNELS-1:0] in_ready_s;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_ch_q,    out_ch_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;

  assign load_s = !out_valid_q || out_ready;

  // Grant evaluation for both modes; an out-of-range sel simply never matches
  always_comb begin
    fx_hit_s = 1'b0;
    lo_hit_s = 1'b0;
    lo_g_s   = '0;
    hi_hit_s = 1'b0;
    hi_g_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_valid[i] && (sel == SELW'(i))) begin
        fx_hit_s = 1'b1;
      end else begin
        fx_hit_s = fx_hit_s;
      end
    end
    // Descending scan leaves the lowest valid index overall (lo) and the
    // lowest valid index at or above ptr (hi); hi wins, lo is the wrap-around.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_hit_s = 1'b1;
        lo_g_s   = SELW'(i);
        if (SELW'(i) >= ptr_q) begin
          hi_hit_s = 1'b1;
          hi_g_s   = SELW'(i);
        end else begin
          hi_hit_s = hi_hit_s;
          hi_g_s   = hi_g_s;
        end
      end else begin
        lo_hit_s = lo_hit_s;
      end
    end
    rr_hit_s = hi_hit_s || lo_hit_s;
    rr_g_s   = hi_hit_s ? hi_g_s : lo_g_s;
    if (mode) begin
      grant_hit_s = rr_hit_s;
      grant_g_s   = rr_g_s;
    end else begin
      grant_hit_s = fx_hit_s;
      grant_g_s   = sel;
    end
  end

  // Data select and per-channel ready for the granted channel
  always_comb begin
    xfer_s     = !rst && load_s && grant_hit_s;
    gnt_data_s = '0;
    in_ready_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready_s[i] = xfer_s && (grant_g_s == SELW'(i));
      if (grant_g_s == SELW'(i)) begin
        gnt_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  assign in_ready = in_ready_s;

  // Next state of the output register and the round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_ch_d    = grant_g_s;
      if (mode) begin
        ptr_d = (grant_g_s == LAST_CH) ? '0 : grant_g_s + SELW'(1'b1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n: a 4-channel and a 3-channel instance share clock and reset.
// Stimulus pushes the expected word; negedge monitors pop and compare on each handshake.
module tb_mux_rr_n;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode4, out_ready4, out_valid4;
  logic [1:0]  sel4, out_ch4;
  logic [3:0]  in_valid4, in_ready4;
  logic [59:0] in_data4;
  logic [14:0] out_data4;

  logic        mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [2:0]  in_valid3, in_ready3;
  logic [44:0] in_data3;
  logic [14:0] out_data3;

  logic [16:0] q4[$];
  logic [16:0] q3[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic        hold4 = 1'b0, hold3 = 1'b0;
  logic [14:0] hold_data4, hold_data3;
  logic [1:0]  hold_ch4, hold_ch3;

  always #5 clk = ~clk;

  mux_rr_n #(.WIDTH(15), .CHANNELS(4), .SELW(2)) u4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
    .out_ready(out_ready4)
  );

  mux_rr_n #(.WIDTH(15), .CHANNELS(3), .SELW(2)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel i carries tag + i*15'h111, so channel 2 with tag 15'h1012 gives 15'h1234.
  task automatic step4(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic rdy, input logic [14:0] tag,
                       input logic [3:0] exp_rdy, input logic [1:0] exp_ch,
                       input logic exp_ov);
    mode4 = m; sel4 = s; in_valid4 = v; out_ready4 = rdy;
    for (int i = 0; i < 4; i++) in_data4[i*15 +: 15] = tag + 15'(i * 273);
    #1;
    chk("in_ready4", 32'(in_ready4), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) q4.push_back({exp_ch, tag + 15'(exp_ch * 273)});
    @(posedge clk); #1;
    chk("out_valid4", 32'(out_valid4), 32'(exp_ov));
  endtask

  task automatic step3(input logic m, input logic [1:0] s, input logic [2:0] v,
                       input logic rdy, input logic [14:0] tag,
                       input logic [2:0] exp_rdy, input logic [1:0] exp_ch,
                       input logic exp_ov);
    mode3 = m; sel3 = s; in_valid3 = v; out_ready3 = rdy;
    for (int i = 0; i < 3; i++) in_data3[i*15 +: 15] = tag + 15'(i * 273);
    #1;
    chk("in_ready3", 32'(in_ready3), 32'(exp_rdy));
    if (exp_rdy != 3'b000) q3.push_back({exp_ch, tag + 15'(exp_ch * 273)});
    @(posedge clk); #1;
    chk("out_valid3", 32'(out_valid3), 32'(exp_ov));
  endtask

  // Monitor for the 4-channel instance: hold stability and scoreboard pops
  always @(negedge clk) begin
    if (hold4) begin
      chk("hold_valid4", 32'(out_valid4), 32'd1);
      chk("hold_data4", 32'(out_data4), 32'(hold_data4));
      chk("hold_ch4", 32'(out_ch4), 32'(hold_ch4));
    end
    hold4      <= (out_valid4 === 1'b1) && (out_ready4 === 1'b0) && (rst === 1'b0);
    hold_data4 <= out_data4;
    hold_ch4   <= out_ch4;
    if (out_valid4 === 1'b1 && out_ready4 === 1'b1 && rst === 1'b0) begin
      if (q4.size() == 0) begin
        chk("unexpected_word4", 32'(out_data4), 32'h7fff_ffff);
      end else begin
        chk("sb_data4", 32'(out_data4), 32'(q4[0][14:0]));
        chk("sb_ch4", 32'(out_ch4), 32'(q4[0][16:15]));
        q4.delete(0);
      end
    end
  end

  // Monitor for the 3-channel instance
  always @(negedge clk) begin
    if (hold3) begin
      chk("hold_valid3", 32'(out_valid3), 32'd1);
      chk("hold_data3", 32'(out_data3), 32'(hold_data3));
      chk("hold_ch3", 32'(out_ch3), 32'(hold_ch3));
    end
    hold3      <= (out_valid3 === 1'b1) && (out_ready3 === 1'b0) && (rst === 1'b0);
    hold_data3 <= out_data3;
    hold_ch3   <= out_ch3;
    if (out_valid3 === 1'b1 && out_ready3 === 1'b1 && rst === 1'b0) begin
      if (q3.size() == 0) begin
        chk("unexpected_word3", 32'(out_data3), 32'h7fff_ffff);
      end else begin
        chk("sb_data3", 32'(out_data3), 32'(q3[0][14:0]));
        chk("sb_ch3", 32'(out_ch3), 32'(q3[0][16:15]));
        q3.delete(0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    mode4 = 1'b1; sel4 = 2'd0; in_valid4 = 4'b1111; in_data4 = '0; out_ready4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000;  in_data3 = '0; out_ready3 = 1'b1;
    @(posedge clk); #1;

    // Reset with every channel valid: nothing is accepted
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0000, 4'b0000, 2'd0, 1'b0);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0000, 4'b0000, 2'd0, 1'b0);
    chk("rst_data4", 32'(out_data4), 32'h0);
    chk("rst_ch4", 32'(out_ch4), 32'h0);
    chk("rst_valid3", 32'(out_valid3), 32'h0);
    rst = 1'b0;

    // Round-robin over all channels, then over channels 1 and 3
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0100, 4'b0001, 2'd0, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0101, 4'b0010, 2'd1, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0102, 4'b0100, 2'd2, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0103, 4'b1000, 2'd3, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0104, 4'b0001, 2'd0, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0105, 4'b0010, 2'd1, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0106, 4'b0100, 2'd2, 1'b1);
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0107, 4'b1000, 2'd3, 1'b1);
    step4(1'b1, 2'd0, 4'b1010, 1'b1, 15'h0200, 4'b0010, 2'd1, 1'b1);
    step4(1'b1, 2'd0, 4'b1010, 1'b1, 15'h0201, 4'b1000, 2'd3, 1'b1);
    step4(1'b1, 2'd0, 4'b1010, 1'b1, 15'h0202, 4'b0010, 2'd1, 1'b1);
    step4(1'b1, 2'd0, 4'b1010, 1'b1, 15'h0203, 4'b1000, 2'd3, 1'b1);

    // Fixed select of channel 2 (first word 15'h1234), then channel 2 idle drains
    step4(1'b0, 2'd2, 4'b1111, 1'b1, 15'h1012, 4'b0100, 2'd2, 1'b1);
    step4(1'b0, 2'd2, 4'b1111, 1'b1, 15'h1013, 4'b0100, 2'd2, 1'b1);
    step4(1'b0, 2'd2, 4'b1011, 1'b1, 15'h0300, 4'b0000, 2'd0, 1'b0);

    // Fixed-mode transfers leave ptr at 0
    step4(1'b1, 2'd0, 4'b1111, 1'b1, 15'h0400, 4'b0001, 2'd0, 1'b1);

    // Back-pressure on a channel-1 word, then refill in the consume cycle
    step4(1'b0, 2'd1, 4'b1111, 1'b1, 15'h0500, 4'b0010, 2'd1, 1'b1);
    step4(1'b0, 2'd1, 4'b1111, 1'b0, 15'h0501, 4'b0000, 2'd0, 1'b1);
    step4(1'b0, 2'd1, 4'b1111, 1'b0, 15'h0502, 4'b0000, 2'd0, 1'b1);
    step4(1'b0, 2'd1, 4'b1111, 1'b0, 15'h0503, 4'b0000, 2'd0, 1'b1);
    step4(1'b0, 2'd1, 4'b1111, 1'b1, 15'h0504, 4'b0010, 2'd1, 1'b1);
    step4(1'b0, 2'd1, 4'b0000, 1'b1, 15'h0505, 4'b0000, 2'd0, 1'b0);

    // Mid-operation reset: ptr is 1 here, the channel-2 grant moves it to 3
    step4(1'b1, 2'd0, 4'b0100, 1'b0, 15'h0600, 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    step4(1'b1, 2'd0, 4'b1010, 1'b0, 15'h0601, 4'b0000, 2'd0, 1'b0);
    chk("mid_rst_data4", 32'(out_data4), 32'h0);
    chk("mid_rst_ch4", 32'(out_ch4), 32'h0);
    q4.delete();
    rst = 1'b0;
    step4(1'b1, 2'd0, 4'b1010, 1'b1, 15'h0700, 4'b0010, 2'd1, 1'b1);
    step4(1'b1, 2'd0, 4'b0000, 1'b1, 15'h0701, 4'b0000, 2'd0, 1'b0);

    // Three channels: round-robin wraps 2 -> 0, out-of-range sel grants nothing
    step3(1'b1, 2'd0, 3'b101, 1'b1, 15'h0800, 3'b001, 2'd0, 1'b1);
    step3(1'b1, 2'd0, 3'b101, 1'b1, 15'h0801, 3'b100, 2'd2, 1'b1);
    step3(1'b1, 2'd0, 3'b101, 1'b1, 15'h0802, 3'b001, 2'd0, 1'b1);
    step3(1'b1, 2'd0, 3'b101, 1'b1, 15'h0803, 3'b100, 2'd2, 1'b1);
    step3(1'b0, 2'd3, 3'b111, 1'b1, 15'h0900, 3'b000, 2'd0, 1'b0);
    chk("sel3_keep_data", 32'(out_data3), 32'h0a25);
    chk("sel3_keep_ch", 32'(out_ch3), 32'h2);
    step3(1'b0, 2'd2, 3'b111, 1'b1, 15'h0a00, 3'b100, 2'd2, 1'b1);
    step3(1'b0, 2'd2, 3'b000, 1'b1, 15'h0a01, 3'b000, 2'd0, 1'b0);

    @(negedge clk);
    chk("sb_empty4", 32'(q4.size()), 32'd0);
    chk("sb_empty3", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
